instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- Upstream stage of the matrix coprocessor. Buffers 32-bit instructions written by the host (HPS PIO side) in a FIFO.
- Issues each instruction to the coprocessor as a stable `instruction` word plus a one-cycle `activate_instruction` pulse.
- Issues the next instruction only after the coprocessor has left and then returned to its fetch state.
- Keeps occupancy, error and issue-count status for host polling.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).
- TIMEOUT, 1024, cycles allowed in WAIT_ACK before a timeout. Used only with INSTR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- host_data  in  32  instruction word from the host.
- host_wr  in  1  write strobe; one push per high cycle.
- host_clr_err  in  1  clears the sticky error flags.
- host_full  out  1  FIFO full.
- host_empty  out  1  FIFO empty.
- host_count  out  AW+1  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky; set when a write is dropped.
- timeout_err  out  1  sticky; set on an issue timeout.
- issued_count  out  16  instructions completed by the coprocessor; wraps.
- cop_idle  in  1  high while the coprocessor FSM is in FETCH.
- instruction  out  32  instruction word to the coprocessor.
- activate_instruction  out  1  one-cycle issue pulse.

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO pointers and count go to 0, and state goes to IDLE. Outputs:
  - instruction=0, activate_instruction=0
  - host_empty=1, host_full=0, host_count=0
  - overflow_err=0, timeout_err=0, issued_count=0
- Reset mid-operation discards every queued and in-flight instruction. activate_instruction drops immediately.
- Push: host_wr=1 with count<DEPTH writes host_data at wptr and increments wptr, wrapping at DEPTH.
- Push while full:
  - If a pop happens in the same cycle, the write is accepted and count is unchanged.
  - Otherwise the word is dropped and overflow_err is set.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Flags are registered and consistent with count every cycle: host_full = (count==DEPTH), host_empty = (count==0).
- FSM states: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If count>0 and cop_idle=1: load instruction with the FIFO head, pop, set activate_instruction=1 for the next cycle, and go to WAIT_ACK.
  - Otherwise stay in IDLE.
- WAIT_ACK:
  - activate_instruction returns to 0 (high for exactly one cycle).
  - cop_idle=0 goes to WAIT_DONE.
  - Otherwise stay in WAIT_ACK.
- WAIT_DONE:
  - cop_idle=1 increments issued_count (mod 2^16) and goes to IDLE.
- instruction holds its value from load until the next load, and is never changed outside the IDLE load.
- Latency: a push into an empty FIFO with cop_idle=1 gives activate_instruction=1 two cycles after the host_wr cycle (one cycle for the write, one for the IDLE decision).
- Back-to-back issue: the minimum spacing between activate pulses is the coprocessor busy time plus 2 cycles.
- host_clr_err=1 clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- Empty FIFO: no issue, and state stays in IDLE indefinitely.

Optional Feature:
- Macro: INSTR_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - If cop_idle stays 1 for TIMEOUT consecutive cycles: set timeout_err, discard the instruction (issued_count unchanged), and return to IDLE.
  - The counter clears on entering WAIT_ACK.
- Undefined:
  - WAIT_ACK waits forever.
  - timeout_err is tied to 0 and no counter logic is generated.

Test Plan:
- Reset then push 0x0000_1235 with cop_idle=1 -> activate_instruction=1 for exactly one cycle, two cycles after host_wr, with instruction=0x0000_1235. Model drops cop_idle for 5 cycles then raises it -> issued_count=1, host_empty=1.
- Push 3 words (A, B, C) while cop_idle=0 -> no activate, host_count=3. Then cycle cop_idle per instruction -> issue order A, B, C, with one pulse each and issued_count=3.
- Push 9 words with DEPTH=8 and the coprocessor busy -> host_full=1, 9th word dropped, overflow_err=1. host_clr_err -> overflow_err=0.
- FIFO full and a pop in the same cycle as host_wr -> write accepted, host_count stays 8, overflow_err stays 0.
- Assert rst_n=0 asynchronously during WAIT_DONE with 4 entries queued -> all outputs at reset values before the next clock edge, and no issue after release.
- With INSTR_TIMEOUT_EN and TIMEOUT=16: issue while cop_idle is held at 1 -> timeout_err=1 after 16 cycles, FSM back in IDLE, issued_count unchanged, next entry issued.

Source files
------------

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: host-fed instruction FIFO that issues one word at a time
// to the matrix coprocessor and waits for the coprocessor to go busy and then
// return to FETCH before it issues the next word.
// Optional feature macro: INSTR_TIMEOUT_EN. When it is defined, WAIT_ACK gives up
// after TIMEOUT cycles with cop_idle still high and sets timeout_err.
module instr_issue_queue #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   host_data,
   input  logic          host_wr,
   input  logic          host_clr_err,
   output logic          host_full,
   output logic          host_empty,
   output logic [AW:0]   host_count,
   output logic          overflow_err,
   output logic          timeout_err,
   output logic [15:0]   issued_count,
   input  logic          cop_idle,
   output logic [31:0]   instruction,
   output logic          activate_instruction
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Parameters that cannot work are rejected at elaboration time.
   if (DEPTH < 2 || (1 << AW) != DEPTH || TIMEOUT < 1) begin : g_bad_params
      $error("instr_issue_queue: DEPTH must be a power of two >= 2 equal to 2**AW, TIMEOUT >= 1");
   end

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   state_t        state;
   state_t        state_next;
   logic          pop;
   logic          push;
   logic          drop;
   logic          is_full;
   logic          issue_done;
   logic          timeout_hit;

`ifdef INSTR_TIMEOUT_EN
   localparam int          TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] to_cnt;
`endif

   assign is_full    = (count == FULL_CNT);
   assign host_count = count;

   // Issue state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: pop the head from IDLE, wait for busy, then wait for FETCH again.
   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      issue_done  = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0 && cop_idle) begin
               pop        = 1'b1;
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!cop_idle) begin
               state_next = WAIT_DONE;
            end
`ifdef INSTR_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end
`endif
         end
         WAIT_DONE: begin
            if (cop_idle) begin
               issue_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A write into a full FIFO is only accepted when the head leaves in the same cycle.
   always_comb begin
      push       = host_wr && (!is_full || pop);
      drop       = host_wr && is_full && !pop;
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage array; contents are meaningless until written so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= host_data;
      end
   end

   // Pointers, occupancy and the registered full/empty flags derived from the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         host_full  <= 1'b0;
         host_empty <= 1'b1;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count      <= count_next;
         host_full  <= (count_next == FULL_CNT);
         host_empty <= (count_next == '0);
      end
   end

   // Issue datapath: latch the head word on pop, pulse activate, count completions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction          <= '0;
         activate_instruction <= 1'b0;
         issued_count         <= '0;
      end else begin
         if (pop) instruction <= mem[rptr];
         activate_instruction <= pop;
         if (issue_done) issued_count <= issued_count + 16'd1;
      end
   end

   // Sticky overflow flag; a new drop beats a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_err <= 1'b0;
      end else if (drop) begin
         overflow_err <= 1'b1;
      end else if (host_clr_err) begin
         overflow_err <= 1'b0;
      end
   end

`ifdef INSTR_TIMEOUT_EN
   // Cycles spent in WAIT_ACK with cop_idle high; restarts every time an instruction is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (pop) begin
         to_cnt <= '0;
      end else if (state == WAIT_ACK) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Sticky timeout flag; a new timeout beats a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err <= 1'b0;
      end else if (timeout_hit) begin
         timeout_err <= 1'b1;
      end else if (host_clr_err) begin
         timeout_err <= 1'b0;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Testbench for instr_issue_queue: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based reference.
module tb_instr_issue_queue;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   host_data;
   logic          host_wr;
   logic          host_clr_err;
   logic          host_full;
   logic          host_empty;
   logic [AW:0]   host_count;
   logic          overflow_err;
   logic          timeout_err;
   logic [15:0]   issued_count;
   logic          cop_idle;
   logic [31:0]   instruction;
   logic          activate_instruction;

   instr_issue_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .host_data            (host_data),
      .host_wr              (host_wr),
      .host_clr_err         (host_clr_err),
      .host_full            (host_full),
      .host_empty           (host_empty),
      .host_count           (host_count),
      .overflow_err         (overflow_err),
      .timeout_err          (timeout_err),
      .issued_count         (issued_count),
      .cop_idle             (cop_idle),
      .instruction          (instruction),
      .activate_instruction (activate_instruction)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: the queue of pending words plus where the current issue handshake stands.
   logic [31:0] mq[$];
   bit          m_busy_seen_wait;   // issued, still waiting for the coprocessor to go busy
   bit          m_wait_return;      // coprocessor went busy, waiting for it to return to FETCH
   int          m_hold_cycles;
   logic [31:0] m_instr;
   bit          m_act;
   bit          m_ovf;
   bit          m_to;
   int          m_issued;

   typedef struct {
      logic        wr;
      logic [31:0] data;
      logic        clr;
      logic        idle;
      int          exp_count;
      logic        exp_act;
      logic [31:0] exp_instr;
      int          exp_issued;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      mq.delete();
      m_busy_seen_wait = 0;
      m_wait_return    = 0;
      m_hold_cycles    = 0;
      m_instr          = 0;
      m_act            = 0;
      m_ovf            = 0;
      m_to             = 0;
      m_issued         = 0;
   endfunction

   // One clock of reference behaviour given the inputs present at that edge.
   function automatic void modelStep(input logic wr, input logic [31:0] data, input logic clr, input logic idle);
      bit can_issue;
      bit ovf_now;
      bit to_now;
      can_issue = !m_busy_seen_wait && !m_wait_return && mq.size() > 0 && idle;
      ovf_now   = 0;
      to_now    = 0;
      if (m_busy_seen_wait) begin
         if (!idle) begin
            m_busy_seen_wait = 0;
            m_wait_return    = 1;
         end else begin
`ifdef INSTR_TIMEOUT_EN
            m_hold_cycles++;
            if (m_hold_cycles == TIMEOUT) begin
               to_now           = 1;
               m_busy_seen_wait = 0;
            end
`endif
         end
      end else if (m_wait_return) begin
         if (idle) begin
            m_wait_return = 0;
            m_issued      = (m_issued + 1) % 65536;
         end
      end
      m_act = can_issue;
      if (can_issue) begin
         m_instr          = mq.pop_front();
         m_busy_seen_wait = 1;
         m_hold_cycles    = 0;
      end
      if (wr) begin
         if (mq.size() < DEPTH) mq.push_back(data);
         else ovf_now = 1;
      end
      m_ovf = ovf_now || (m_ovf && !clr);
      m_to  = to_now  || (m_to  && !clr);
   endfunction

   task automatic checkModel();
      checkOutput("count",   32'(host_count),           32'(mq.size()));
      checkOutput("full",    32'(host_full),            32'(mq.size() == DEPTH));
      checkOutput("empty",   32'(host_empty),           32'(mq.size() == 0));
      checkOutput("act",     32'(activate_instruction), 32'(m_act));
      checkOutput("instr",   instruction,               m_instr);
      checkOutput("issued",  32'(issued_count),         32'(m_issued));
      checkOutput("ovf_err", 32'(overflow_err),         32'(m_ovf));
      checkOutput("to_err",  32'(timeout_err),          32'(m_to));
   endtask

   // Drive one cycle of inputs on the falling edge, then compare just after the rising edge.
   task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic clr, input logic idle);
      @(negedge clk);
      host_wr      = wr;
      host_data    = data;
      host_clr_err = clr;
      cop_idle     = idle;
      modelStep(wr, data, clr, idle);
      @(posedge clk);
      #1;
      checkModel();
   endtask

   task automatic doReset();
      @(negedge clk);
      host_wr      = 1'b0;
      host_clr_err = 1'b0;
      rst_n        = 1'b0;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] seen[$];
   logic [31:0] abc[3];
   int          pulses;
   int          hold;

   initial begin
      // Push 0x1235 with coprocessor idle, then busy for 5 cycles, then back in FETCH.
      vecs[0] = '{1'b1, 32'h0000_1235, 1'b0, 1'b1, 1, 1'b0, 32'h0,         0};
      vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 0, 1'b1, 32'h0000_1235, 0};
      vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0000_1235, 0};
      vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0000_1235, 0};
      vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0000_1235, 0};
      vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0000_1235, 0};
      vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0000_1235, 0};
      vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 0, 1'b0, 32'h0000_1235, 1};
      vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 0, 1'b0, 32'h0000_1235, 1};

      rst_n        = 1'b0;
      host_wr      = 1'b0;
      host_data    = '0;
      host_clr_err = 1'b0;
      cop_idle     = 1'b1;
      modelReset();
      #12;
      $display("[TB] reset state");
      checkOutput("rst instr",  instruction,                32'h0);
      checkOutput("rst act",    32'(activate_instruction),  32'h0);
      checkOutput("rst empty",  32'(host_empty),            32'h1);
      checkOutput("rst full",   32'(host_full),             32'h0);
      checkOutput("rst count",  32'(host_count),            32'h0);
      checkOutput("rst ovf",    32'(overflow_err),          32'h0);
      checkOutput("rst to",     32'(timeout_err),           32'h0);
      checkOutput("rst issued", 32'(issued_count),          32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] single issue vector table");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].clr, vecs[i].idle);
         checkOutput($sformatf("vec%0d count", i),  32'(host_count),           32'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d empty", i),  32'(host_empty),           32'(vecs[i].exp_count == 0));
         checkOutput($sformatf("vec%0d act", i),    32'(activate_instruction), 32'(vecs[i].exp_act));
         checkOutput($sformatf("vec%0d instr", i),  instruction,               vecs[i].exp_instr);
         checkOutput($sformatf("vec%0d issued", i), 32'(issued_count),         32'(vecs[i].exp_issued));
      end

      $display("[TB] in-order issue of three queued words");
      abc = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, abc[i], 1'b0, 1'b0);
      checkOutput("abc count", 32'(host_count), 32'd3);
      checkOutput("abc act",   32'(activate_instruction), 32'd0);
      pulses = 0;
      for (int n = 0; n < 3; n++) begin
         for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, (c == 0 || c == 3));
            if (activate_instruction === 1'b1) begin
               pulses++;
               seen.push_back(instruction);
            end
         end
      end
      checkOutput("abc pulses", 32'(pulses), 32'd3);
      checkOutput("abc seen",   32'(seen.size()), 32'd3);
      for (int i = 0; i < 3 && i < seen.size(); i++)
         checkOutput($sformatf("abc order%0d", i), seen[i], abc[i]);
      checkOutput("abc issued", 32'(issued_count), 32'd4);

      $display("[TB] overflow and clear");
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      checkOutput("ovf full",  32'(host_full),    32'd1);
      checkOutput("ovf count", 32'(host_count),   32'd8);
      checkOutput("ovf flag",  32'(overflow_err), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("ovf clr",   32'(overflow_err), 32'd0);

      $display("[TB] write while full with a simultaneous pop");
      applyStimulus(1'b1, 32'hBEEF_0000, 1'b0, 1'b1);
      checkOutput("fullpop count", 32'(host_count),           32'd8);
      checkOutput("fullpop ovf",   32'(overflow_err),         32'd0);
      checkOutput("fullpop act",   32'(activate_instruction), 32'd1);
      checkOutput("fullpop instr", instruction,               32'h100);

      $display("[TB] asynchronous reset during WAIT_DONE");
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("ar pre count", 32'(host_count), 32'd4);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar instr", instruction,               32'h0);
      checkOutput("ar act",   32'(activate_instruction), 32'h0);
      checkOutput("ar count", 32'(host_count),           32'h0);
      checkOutput("ar empty", 32'(host_empty),           32'h1);
      checkOutput("ar full",  32'(host_full),            32'h0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

`ifdef INSTR_TIMEOUT_EN
      $display("[TB] issue timeout");
      doReset();
      applyStimulus(1'b1, 32'h3000_0001, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h3000_0002, 1'b0, 1'b1);
      hold = 0;
      for (int i = 0; i < 40 && timeout_err !== 1'b1; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
         hold++;
      end
      checkOutput("to cycles", 32'(hold),         32'(TIMEOUT));
      checkOutput("to flag",   32'(timeout_err),  32'd1);
      checkOutput("to issued", 32'(issued_count), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("to next act",   32'(activate_instruction), 32'd1);
      checkOutput("to next instr", instruction,               32'h3000_0002);
`else
      $display("[TB] WAIT_ACK with cop_idle held high never gives up");
      doReset();
      applyStimulus(1'b1, 32'h3000_0001, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h3000_0002, 1'b0, 1'b1);
      for (int i = 0; i < 2 * TIMEOUT; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("noto flag",  32'(timeout_err), 32'd0);
      checkOutput("noto count", 32'(host_count),  32'd1);
`endif

      $display("[TB] randomized traffic");
      doReset();
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 5,
                       $urandom_range(0, 99) < 60);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
